// File: rtl/sram_wait_ctl_pkg.sv
// Shared types and defaults for the async-SRAM wait-state controller.
// Holds the FSM state encoding and the wait-counter sizing helper.

package sram_wait_ctl_pkg;

    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_ADDR_W  = 20;
    localparam int unsigned DEF_RD_WAIT = 1;
    localparam int unsigned DEF_WR_WAIT = 2;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StWsu,
        StWpl,
        StWhd
    } sram_st_e;

    // Counter must hold the largest preload value, i.e. max(RD_WAIT, WR_WAIT) - 1.
    function automatic int unsigned cnt_width(input int unsigned rd_wait,
                                              input int unsigned wr_wait);
        int unsigned max_wait;
        max_wait = (rd_wait > wr_wait) ? rd_wait : wr_wait;
        return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
    endfunction

endpackage

// File: rtl/sram_wait_ctl_if.sv
// CPU request/response and SRAM pin bundle for sram_wait_ctl.
// The slave modport is the controller; master is the CPU side plus SRAM model.

interface sram_wait_ctl_if
    import sram_wait_ctl_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) ();

    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_we_i;
    logic [DATA_W/8-1:0]   req_be_i;
    logic [31:0]           req_addr_i;
    logic [DATA_W-1:0]     req_wdata_i;
    logic                  resp_valid_o;
    logic [DATA_W-1:0]     resp_rdata_o;
    logic [DATA_W-1:0]     ram_rdata;
    logic [DATA_W-1:0]     ram_wdata;
    logic [ADDR_W-1:0]     ram_addr;
    logic [DATA_W/8-1:0]   ram_be_n;
    logic                  ram_ce_n;
    logic                  ram_oe_n;
    logic                  ram_we_n;

    modport slave (
        input  req_valid_i, req_we_i, req_be_i, req_addr_i, req_wdata_i, ram_rdata,
        output req_ready_o, resp_valid_o, resp_rdata_o,
        output ram_wdata, ram_addr, ram_be_n, ram_ce_n, ram_oe_n, ram_we_n
    );

    modport master (
        output req_valid_i, req_we_i, req_be_i, req_addr_i, req_wdata_i, ram_rdata,
        input  req_ready_o, resp_valid_o, resp_rdata_o,
        input  ram_wdata, ram_addr, ram_be_n, ram_ce_n, ram_oe_n, ram_we_n
    );

endinterface

// File: rtl/sram_wait_ctl_cnt.sv
// Down-counter for SRAM wait states: load N-1, decrement, flag zero.
// Holds at zero rather than wrapping if decremented there.

module sram_wait_ctl_cnt
    import sram_wait_ctl_pkg::*;
#(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic [WIDTH-1:0] o_value,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_value = r_cnt;
    assign o_zero  = (r_cnt == '0);

endmodule

// File: rtl/sram_wait_ctl.sv
// Single-port async-SRAM controller with valid/ready requests, a one-cycle response
// pulse, configurable read wait and a write setup/pulse/hold sequence.

module sram_wait_ctl
    import sram_wait_ctl_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned RD_WAIT = DEF_RD_WAIT,
    parameter int unsigned WR_WAIT = DEF_WR_WAIT
) (
    input  logic           clk_i,
    input  logic           rst_i,
    sram_wait_ctl_if.slave bus
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned CNT_W = cnt_width(RD_WAIT, WR_WAIT);
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_WAIT - 1);

    sram_st_e          r_state, w_state_d;
    logic              r_ce_n, w_ce_n_d;
    logic              r_oe_n, w_oe_n_d;
    logic              r_we_n, w_we_n_d;
    logic [BE_W-1:0]   r_be_n, w_be_n_d;
    logic [BE_W-1:0]   r_be, w_be_d;
    logic [ADDR_W-1:0] r_addr, w_addr_d;
    logic [DATA_W-1:0] r_wdata, w_wdata_d;
    logic [DATA_W-1:0] r_rdata, w_rdata_d;
    logic              r_resp, w_resp_d;

    logic              w_cnt_load;
    logic [CNT_W-1:0]  w_cnt_load_val;
    logic              w_cnt_dec;
    logic              w_cnt_zero;
    logic [CNT_W-1:0]  w_unused_cnt_value;
    logic              w_unused_addr;

    sram_wait_ctl_cnt #(
        .WIDTH (CNT_W)
    ) u_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_load_val),
        .i_dec      (w_cnt_dec),
        .o_value    (w_unused_cnt_value),
        .o_zero     (w_cnt_zero)
    );

    // Byte offset and high address bits are don't-care.
    assign w_unused_addr = ^{bus.req_addr_i[1:0], bus.req_addr_i[31:ADDR_W+2]};

    // Strobes are computed for the next state and registered, so pins come straight from flops.
    always_comb begin
        w_state_d      = r_state;
        w_ce_n_d       = 1'b1;
        w_oe_n_d       = 1'b1;
        w_we_n_d       = 1'b1;
        w_be_n_d       = '1;
        w_be_d         = r_be;
        w_addr_d       = r_addr;
        w_wdata_d      = r_wdata;
        w_rdata_d      = r_rdata;
        w_resp_d       = 1'b0;
        w_cnt_load     = 1'b0;
        w_cnt_load_val = '0;
        w_cnt_dec      = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (bus.req_valid_i) begin
                    w_addr_d  = bus.req_addr_i[ADDR_W+1:2];
                    w_wdata_d = bus.req_wdata_i;
                    w_be_d    = bus.req_be_i;
                    w_ce_n_d  = 1'b0;
                    if (bus.req_we_i) begin
                        w_state_d = StWsu;
                        w_be_n_d  = ~bus.req_be_i;
                    end else begin
                        w_state_d      = StRd;
                        w_oe_n_d       = 1'b0;
                        w_be_n_d       = '0;
                        w_cnt_load     = 1'b1;
                        w_cnt_load_val = RD_LOAD;
                    end
                end
            end
            StRd: begin
                if (w_cnt_zero) begin
                    w_state_d = StIdle;
                    w_rdata_d = bus.ram_rdata;
                    w_resp_d  = 1'b1;
                end else begin
                    w_cnt_dec = 1'b1;
                    w_ce_n_d  = 1'b0;
                    w_oe_n_d  = 1'b0;
                    w_be_n_d  = '0;
                end
            end
            StWsu: begin
                w_ce_n_d = 1'b0;
                w_be_n_d = ~r_be;
                // No enabled bytes: skip the pulse entirely so we_n never falls.
                if (r_be == '0) begin
                    w_state_d = StWhd;
                end else begin
                    w_state_d      = StWpl;
                    w_we_n_d       = 1'b0;
                    w_cnt_load     = 1'b1;
                    w_cnt_load_val = WR_LOAD;
                end
            end
            StWpl: begin
                w_ce_n_d = 1'b0;
                w_be_n_d = ~r_be;
                if (w_cnt_zero) begin
                    w_state_d = StWhd;
                end else begin
                    w_cnt_dec = 1'b1;
                    w_we_n_d  = 1'b0;
                end
            end
            StWhd: begin
                w_state_d = StIdle;
                w_resp_d  = 1'b1;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= StIdle;
            r_ce_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_we_n  <= 1'b1;
            r_be_n  <= '1;
            r_be    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_resp  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_ce_n  <= w_ce_n_d;
            r_oe_n  <= w_oe_n_d;
            r_we_n  <= w_we_n_d;
            r_be_n  <= w_be_n_d;
            r_be    <= w_be_d;
            r_addr  <= w_addr_d;
            r_wdata <= w_wdata_d;
            r_rdata <= w_rdata_d;
            r_resp  <= w_resp_d;
        end
    end

    assign bus.req_ready_o  = (r_state == StIdle);
    assign bus.resp_valid_o = r_resp;
    assign bus.resp_rdata_o = r_rdata;
    assign bus.ram_wdata    = r_wdata;
    assign bus.ram_addr     = r_addr;
    assign bus.ram_be_n     = r_be_n;
    assign bus.ram_ce_n     = r_ce_n;
    assign bus.ram_oe_n     = r_oe_n;
    assign bus.ram_we_n     = r_we_n;

endmodule

// File: tb/tb_sram_wait_ctl.sv
// Scoreboard bench for sram_wait_ctl: two builds (RD_WAIT=1/WR_WAIT=2 and 3/1),
// directed requests, per-cycle pin trace and a response monitor per instance.

module tb_sram_wait_ctl;

    typedef struct {
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_load = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_wait_ctl_if #(.DATA_W(32), .ADDR_W(20)) bus_a ();
    sram_wait_ctl_if #(.DATA_W(32), .ADDR_W(20)) bus_b ();

    sram_wait_ctl #(.DATA_W(32), .ADDR_W(20), .RD_WAIT(1), .WR_WAIT(2)) u_dut_a (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_a)
    );

    sram_wait_ctl #(.DATA_W(32), .ADDR_W(20), .RD_WAIT(3), .WR_WAIT(1)) u_dut_b (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_b)
    );

    logic        v_valid [2];
    logic        v_we    [2];
    logic [3:0]  v_be    [2];
    logic [31:0] v_addr  [2];
    logic [31:0] v_wdata [2];

    assign bus_a.req_valid_i = v_valid[0];
    assign bus_a.req_we_i    = v_we[0];
    assign bus_a.req_be_i    = v_be[0];
    assign bus_a.req_addr_i  = v_addr[0];
    assign bus_a.req_wdata_i = v_wdata[0];
    assign bus_b.req_valid_i = v_valid[1];
    assign bus_b.req_we_i    = v_we[1];
    assign bus_b.req_be_i    = v_be[1];
    assign bus_b.req_addr_i  = v_addr[1];
    assign bus_b.req_wdata_i = v_wdata[1];

    // SRAM model for instance A; instance B returns an address-derived pattern.
    logic [31:0] mem_a [16];
    assign bus_a.ram_rdata = mem_a[bus_a.ram_addr[3:0]];
    assign bus_b.ram_rdata = 32'hC0DE_0000 | {12'h0, bus_b.ram_addr};

    always @(negedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 16; i++) mem_a[i] <= 32'h0;
            mem_a[2] <= 32'h1111_2222;
            mem_a[3] <= 32'h3333_3333;
            mem_a[4] <= 32'hA5A5_1234;
        end else if (!bus_a.ram_ce_n && !bus_a.ram_we_n) begin
            for (int b = 0; b < 4; b++) begin
                if (!bus_a.ram_be_n[b]) begin
                    mem_a[bus_a.ram_addr[3:0]][8*b +: 8] <= bus_a.ram_wdata[8*b +: 8];
                end
            end
        end
    end

    logic        tr_ce   [2][1024];
    logic        tr_oe   [2][1024];
    logic        tr_we   [2][1024];
    logic [3:0]  tr_be_n [2][1024];
    logic [19:0] tr_addr [2][1024];

    always @(negedge clk) begin
        tr_ce[0][cyc % 1024]   <= bus_a.ram_ce_n;
        tr_oe[0][cyc % 1024]   <= bus_a.ram_oe_n;
        tr_we[0][cyc % 1024]   <= bus_a.ram_we_n;
        tr_be_n[0][cyc % 1024] <= bus_a.ram_be_n;
        tr_addr[0][cyc % 1024] <= bus_a.ram_addr;
        tr_ce[1][cyc % 1024]   <= bus_b.ram_ce_n;
        tr_oe[1][cyc % 1024]   <= bus_b.ram_oe_n;
        tr_we[1][cyc % 1024]   <= bus_b.ram_we_n;
        tr_be_n[1][cyc % 1024] <= bus_b.ram_be_n;
        tr_addr[1][cyc % 1024] <= bus_b.ram_addr;
    end

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void flag(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endfunction

    exp_t q_a[$];
    exp_t q_b[$];

    always @(negedge clk) begin
        exp_t e;
        if (bus_a.resp_valid_o) begin
            if (q_a.size() == 0) begin
                flag("a_unexpected_resp");
            end else begin
                e = q_a.pop_front();
                chk("a_resp_cycle", cyc, e.cyc);
                chk("a_resp_rdata", bus_a.resp_rdata_o, e.rdata);
            end
        end
        if (bus_b.resp_valid_o) begin
            if (q_b.size() == 0) begin
                flag("b_unexpected_resp");
            end else begin
                e = q_b.pop_front();
                chk("b_resp_cycle", cyc, e.cyc);
                chk("b_resp_rdata", bus_b.resp_rdata_o, e.rdata);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives a request and waits for acceptance; lat < 0 means no response is expected.
    task automatic issue(input int d, input logic we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wdata, input int lat,
                         input logic [31:0] exp_rd, output int t);
        int   budget;
        logic rdy;
        exp_t e;
        v_we[d]    = we;
        v_addr[d]  = addr;
        v_be[d]    = be;
        v_wdata[d] = wdata;
        v_valid[d] = 1'b1;
        budget     = 0;
        t          = -1;
        while (t < 0 && budget < 50) begin
            @(negedge clk);
            rdy = (d == 0) ? bus_a.req_ready_o : bus_b.req_ready_o;
            if (rdy) t = cyc;
            budget++;
        end
        if (t < 0) begin
            flag("accept_timeout");
        end else if (lat >= 0) begin
            e.rdata = exp_rd;
            e.cyc   = t + lat;
            if (d == 0) q_a.push_back(e);
            else q_b.push_back(e);
        end
        step();
    endtask

    function automatic int count_low(input int d, input int from, input int to);
        int n = 0;
        for (int c = from; c <= to; c++) if (tr_we[d][c % 1024] == 1'b0) n++;
        return n;
    endfunction

    function automatic int count_oe_low(input int d, input int from, input int to);
        int n = 0;
        for (int c = from; c <= to; c++) if (tr_oe[d][c % 1024] == 1'b0) n++;
        return n;
    endfunction

    initial begin
        int t, t2, budget;
        for (int d = 0; d < 2; d++) begin
            v_valid[d] = 1'b0;
            v_we[d]    = 1'b0;
            v_be[d]    = 4'h0;
            v_addr[d]  = 32'h0;
            v_wdata[d] = 32'h0;
        end
        repeat (3) step();
        rst      = 1'b0;
        mem_load = 1'b0;
        repeat (5) step();

        @(negedge clk);
        chk("rst_ce_n", bus_a.ram_ce_n, 1'b1);
        chk("rst_oe_n", bus_a.ram_oe_n, 1'b1);
        chk("rst_we_n", bus_a.ram_we_n, 1'b1);
        chk("rst_be_n", bus_a.ram_be_n, 4'hF);
        chk("rst_ready", bus_a.req_ready_o, 1'b1);
        chk("rst_resp_valid", bus_a.resp_valid_o, 1'b0);
        chk("rst_addr", bus_a.ram_addr, 20'h0);
        chk("rst_rdata", bus_a.resp_rdata_o, 32'h0);
        chk("rst_b_ce_n", bus_b.ram_ce_n, 1'b1);
        step();

        // Read word 4, one wait state.
        issue(0, 1'b0, 32'h0000_0010, 4'hF, 32'h0, 2, 32'hA5A5_1234, t);
        v_valid[0] = 1'b0;
        repeat (3) step();
        chk("rd_addr", tr_addr[0][(t + 1) % 1024], 20'h4);
        chk("rd_ce_n", tr_ce[0][(t + 1) % 1024], 1'b0);
        chk("rd_be_n", tr_be_n[0][(t + 1) % 1024], 4'h0);
        chk("rd_oe_low_cycles", count_oe_low(0, t, t + 3), 1);

        // Partial write to word 2: setup, two-cycle pulse, hold.
        issue(0, 1'b1, 32'h0000_0008, 4'b0011, 32'hDEAD_BEEF, 5, 32'hA5A5_1234, t);
        v_valid[0] = 1'b0;
        repeat (6) step();
        chk("wr_setup_we_n", tr_we[0][(t + 1) % 1024], 1'b1);
        chk("wr_setup_oe_n", tr_oe[0][(t + 1) % 1024], 1'b1);
        chk("wr_pulse1_we_n", tr_we[0][(t + 2) % 1024], 1'b0);
        chk("wr_pulse2_we_n", tr_we[0][(t + 3) % 1024], 1'b0);
        chk("wr_hold_we_n", tr_we[0][(t + 4) % 1024], 1'b1);
        chk("wr_hold_ce_n", tr_ce[0][(t + 4) % 1024], 1'b0);
        chk("wr_after_ce_n", tr_ce[0][(t + 5) % 1024], 1'b1);
        chk("wr_we_low_cycles", count_low(0, t, t + 6), 2);
        for (int c = 1; c <= 4; c++) begin
            chk("wr_addr_stable", tr_addr[0][(t + c) % 1024], 20'h2);
            chk("wr_be_n_stable", tr_be_n[0][(t + c) % 1024], 4'b1100);
        end

        issue(0, 1'b0, 32'h0000_0008, 4'hF, 32'h0, 2, 32'h1111_BEEF, t);
        v_valid[0] = 1'b0;
        repeat (3) step();

        // Write with no byte enables: acknowledged, but we_n must never fall.
        issue(0, 1'b1, 32'h0000_000C, 4'b0000, 32'hFFFF_FFFF, 3, 32'h1111_BEEF, t);
        v_valid[0] = 1'b0;
        repeat (4) step();
        chk("wr_be0_we_low_cycles", count_low(0, t, t + 4), 0);
        chk("wr_be0_ce_setup", tr_ce[0][(t + 1) % 1024], 1'b0);
        chk("wr_be0_ce_hold", tr_ce[0][(t + 2) % 1024], 1'b0);

        // Read then write with valid held: write accepted in the read's response cycle.
        issue(0, 1'b0, 32'h0000_000C, 4'hF, 32'h0, 2, 32'h3333_3333, t);
        issue(0, 1'b1, 32'h0000_0004, 4'hF, 32'h0BAD_F00D, 5, 32'h3333_3333, t2);
        v_valid[0] = 1'b0;
        chk("b2b_accept_cycle", t2, t + 2);
        repeat (7) step();

        // Reset during the write pulse aborts with no response.
        issue(0, 1'b1, 32'h0000_0014, 4'hF, 32'h7777_7777, -1, 32'h0, t);
        v_valid[0] = 1'b0;
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("abort_in_wpl_we_n", bus_a.ram_we_n, 1'b0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("abort_we_n", bus_a.ram_we_n, 1'b1);
        chk("abort_ce_n", bus_a.ram_ce_n, 1'b1);
        chk("abort_ready", bus_a.req_ready_o, 1'b1);
        chk("abort_resp_valid", bus_a.resp_valid_o, 1'b0);
        chk("abort_rdata", bus_a.resp_rdata_o, 32'h0);
        repeat (5) step();

        issue(0, 1'b0, 32'h0000_0004, 4'hF, 32'h0, 2, 32'h0BAD_F00D, t);
        v_valid[0] = 1'b0;
        repeat (3) step();

        // Build B: three read wait states, single-cycle write pulse.
        issue(1, 1'b0, 32'h0000_0020, 4'hF, 32'h0, 4, 32'hC0DE_0008, t);
        v_valid[1] = 1'b0;
        repeat (5) step();
        chk("b_rd_oe_low_cycles", count_oe_low(1, t, t + 5), 3);
        chk("b_rd_addr", tr_addr[1][(t + 1) % 1024], 20'h8);

        issue(1, 1'b1, 32'h0000_0024, 4'b1000, 32'h1234_5678, 4, 32'hC0DE_0008, t);
        v_valid[1] = 1'b0;
        repeat (5) step();
        chk("b_wr_we_low_cycles", count_low(1, t, t + 5), 1);
        chk("b_wr_pulse_we_n", tr_we[1][(t + 2) % 1024], 1'b0);
        chk("b_wr_be_n", tr_be_n[1][(t + 1) % 1024], 4'b0111);

        budget = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && budget < 20) begin
            step();
            budget++;
        end
        chk("a_pending_resp", q_a.size(), 0);
        chk("b_pending_resp", q_b.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
